// File: rtl/uart_rx_parity_check.sv
// UART receive framer: oversampled start detection, LSB-first deserialisation,
// optional odd-parity check and stop-bit check, with one-cycle result pulses.
module uart_rx_parity_check #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  parity_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_s_d;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         data_idx;
    logic                  samp0;
    logic                  samp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  par_en_l;

    logic start_edge;
    logic decide;
    logic bit_end;
    logic majority;
    logic par_err;

    assign start_edge = rx_s_d & ~rx_s;
    assign decide     = (bit_cnt == CNT_DEC);
    assign bit_end    = (bit_cnt == CNT_LAST);
    assign majority   = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    // Odd parity: the expected parity bit is the XNOR-reduction of the payload.
    assign par_err    = par_en_l & (par_bit != ~^shreg);

    // Synchroniser resets to the idle (high) line level so reset release
    // never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) state_nxt = START;
            end
            START: begin
                if (decide && majority) state_nxt = IDLE;
                else if (bit_end)       state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && data_idx == IDX_LAST)
                    state_nxt = par_en_l ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                // Leave mid stop bit so a start edge at the next boundary is seen.
                if (decide) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shift register and parity capture are reset along with the
            // control path; rx_data is loaded from shreg, so its reset value must be defined.
            bit_cnt       <= '0;
            data_idx      <= '0;
            samp0         <= 1'b1;
            samp1         <= 1'b1;
            shreg         <= '0;
            par_bit       <= 1'b0;
            par_en_l      <= 1'b0;
            rx_data       <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (state == IDLE) begin
                bit_cnt  <= '0;
                data_idx <= '0;
                if (start_edge) par_en_l <= parity_en;
            end else begin
                bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
                if (bit_cnt == CNT_S0) samp0 <= rx_s;
                if (bit_cnt == CNT_S1) samp1 <= rx_s;
                if (state == DATA && bit_end) data_idx <= data_idx + IW'(1);
                if (decide) begin
                    case (state)
                        DATA:   shreg   <= {majority, shreg[DATA_WIDTH-1:1]};
                        PARITY: par_bit <= majority;
                        STOP: begin
                            rx_data       <= shreg;
                            framing_error <= ~majority;
                            parity_error  <= par_err;
                            data_valid    <= majority & ~par_err;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
